relu_maxpool: RTL and testbench

RELU_MAXPOOL -- requirements
Module: relu_maxpool

---
 rtl/cnn_pkg.sv | 14 +
 rtl/pool_row_buffer.sv | 26 ++
 rtl/relu_maxpool.sv | 114 +++++++++++
 tb/tb_relu_maxpool.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN defaults and relu/maxpool FSM encoding
package cnn_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int H_DEF      = 26;
  localparam int W_DEF      = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pool_row_buffer.sv
// rtl/pool_row_buffer.sv - register row buffer holding even-row pair maxima
module pool_row_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = W_DEF / 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  // No reset: every entry is rewritten on an even row before the odd row reads it.
  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/relu_maxpool.sv
// rtl/relu_maxpool.sv - streaming ReLU followed by 2x2 stride-2 max pooling
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int H      = H_DEF,
  parameter int W      = W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [7:0]               out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int BD = (W / 2 > 0) ? W / 2 : 1;
  localparam int AW = (BD > 1) ? $clog2(BD) : 1;

  state_t                   state, state_nx;
  logic [CW-1:0]            c;
  logic [RW-1:0]            r;
  logic [7:0]               out_cnt;
  logic                     accept, last_in, buf_wr;
  logic [AW-1:0]            buf_addr;
  logic signed [DATA_W-1:0] relu_val, even_val, pair_max, buf_rd, win_max;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_in) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign last_in  = accept && (c == CW'(W - 1)) && (r == RW'(H - 1));
  assign relu_val = in_data[DATA_W-1] ? '0 : in_data;
  assign pair_max = (relu_val > even_val) ? relu_val : even_val;
  assign win_max  = (buf_rd > pair_max) ? buf_rd : pair_max;
  assign buf_addr = AW'(c >> 1);
  // Odd trailing row/column always lands on an even index, so parity alone drops it.
  assign buf_wr   = accept && c[0] && !r[0];

  pool_row_buffer #(
    .DEPTH  (BD),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_row_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (buf_addr),
    .wr_data (pair_max),
    .rd_addr (buf_addr),
    .rd_data (buf_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c         <= '0;
      r         <= '0;
      out_cnt   <= '0;
      even_val  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (state == IDLE && start) begin
        c       <= '0;
        r       <= '0;
        out_cnt <= '0;
      end else if (accept) begin
        if (c == CW'(W - 1)) begin
          c <= '0;
          r <= (r == RW'(H - 1)) ? '0 : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
        if (!c[0]) begin
          even_val <= relu_val;
        end else if (r[0]) begin
          out_valid <= 1'b1;
          out_data  <= win_max;
          out_addr  <= out_cnt;
          out_cnt   <= out_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// tb/tb_relu_maxpool.sv - directed self-checking bench for relu_maxpool
module tb_relu_maxpool;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int tests_run = 0;
  int tests_failed = 0;

  // d: 26x26 default, a: 4x4, b: 2x2, e: 4x5
  logic d_start, d_in_valid, d_in_ready, d_out_valid, d_busy, d_done;
  logic signed [31:0] d_in_data, d_out_data;
  logic [7:0] d_out_addr;
  logic a_start, a_in_valid, a_in_ready, a_out_valid, a_busy, a_done;
  logic signed [31:0] a_in_data, a_out_data;
  logic [7:0] a_out_addr;
  logic b_start, b_in_valid, b_in_ready, b_out_valid, b_busy, b_done;
  logic signed [31:0] b_in_data, b_out_data;
  logic [7:0] b_out_addr;
  logic e_start, e_in_valid, e_in_ready, e_out_valid, e_busy, e_done;
  logic signed [31:0] e_in_data, e_out_data;
  logic [7:0] e_out_addr;

  relu_maxpool u_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .in_valid(d_in_valid), .in_data(d_in_data),
    .in_ready(d_in_ready), .out_valid(d_out_valid), .out_data(d_out_data),
    .out_addr(d_out_addr), .busy(d_busy), .done(d_done));
  relu_maxpool #(.H(4), .W(4), .DATA_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_addr(a_out_addr), .busy(a_busy), .done(a_done));
  relu_maxpool #(.H(2), .W(2), .DATA_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_addr(b_out_addr), .busy(b_busy), .done(b_done));
  relu_maxpool #(.H(4), .W(5), .DATA_W(32)) u_e (
    .clk(clk), .rst_n(rst_n), .start(e_start), .in_valid(e_in_valid), .in_data(e_in_data),
    .in_ready(e_in_ready), .out_valid(e_out_valid), .out_data(e_out_data),
    .out_addr(e_out_addr), .busy(e_busy), .done(e_done));

  logic signed [31:0] d_qd[$], a_qd[$], e_qd[$];
  logic [7:0] d_qa[$], a_qa[$], e_qa[$];
  int d_ndone = 0, a_ndone = 0, b_ndone = 0, e_ndone = 0;
  bit d_dwv = 0, a_dwv = 0;

  always @(negedge clk) begin
    if (d_out_valid) begin d_qd.push_back(d_out_data); d_qa.push_back(d_out_addr); end
    if (d_done) d_ndone++;
    if (d_done && d_out_valid) d_dwv = 1;
    if (a_out_valid) begin a_qd.push_back(a_out_data); a_qa.push_back(a_out_addr); end
    if (a_done) a_ndone++;
    if (a_done && a_out_valid) a_dwv = 1;
    if (b_done) b_ndone++;
    if (e_out_valid) begin e_qd.push_back(e_out_data); e_qa.push_back(e_out_addr); end
    if (e_done) e_ndone++;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({d_in_ready, d_out_valid, d_busy, d_done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0000", {d_in_ready, d_out_valid, d_busy, d_done});
    end
    tests_run++;
    if (d_out_data !== 32'sd0 || d_out_addr !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_out: data %0d addr %0d expected 0 0", d_out_data, d_out_addr);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d_in_valid = 1'b1;
      d_in_data  = $urandom;
      @(negedge clk);
      tests_run++;
      if ({d_in_ready, d_out_valid, d_busy} !== 3'b000) begin
        tests_failed++;
        $display("FAIL idle_ignore cycle %0d: got %b expected 000", i, {d_in_ready, d_out_valid, d_busy});
      end
    end
    d_in_valid = 1'b0;
  endtask

  task automatic feed_a(input logic signed [31:0] first, input logic signed [31:0] step);
    a_qd.delete(); a_qa.delete(); a_ndone = 0; a_dwv = 0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = first + step * i;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_small_frame;
    logic signed [31:0] exp_d [4];
    exp_d[0] = 6; exp_d[1] = 8; exp_d[2] = 14; exp_d[3] = 16;
    feed_a(32'sd1, 32'sd1);
    tests_run++;
    if (a_qd.size() != 4) begin
      tests_failed++;
      $display("FAIL small_count: got %0d expected 4", a_qd.size());
    end
    for (int i = 0; i < 4 && i < a_qd.size(); i++) begin
      tests_run++;
      if (a_qd[i] !== exp_d[i] || a_qa[i] !== 8'(i)) begin
        tests_failed++;
        $display("FAIL small_out%0d: got %0d@%0d expected %0d@%0d", i, a_qd[i], a_qa[i], exp_d[i], i);
      end
    end
    tests_run++;
    if (a_ndone != 1 || !a_dwv) begin
      tests_failed++;
      $display("FAIL small_done: got %0d pulses coincident=%0d expected 1 coincident=1", a_ndone, a_dwv);
    end
  endtask

  task automatic test_all_negative;
    feed_a(-32'sd5, 32'sd0);
    tests_run++;
    if (a_qd.size() != 4) begin
      tests_failed++;
      $display("FAIL neg_count: got %0d expected 4", a_qd.size());
    end
    for (int i = 0; i < 4 && i < a_qd.size(); i++) begin
      tests_run++;
      if (a_qd[i] !== 32'sd0 || a_qa[i] !== 8'(i)) begin
        tests_failed++;
        $display("FAIL neg_out%0d: got %0d@%0d expected 0@%0d", i, a_qd[i], a_qa[i], i);
      end
    end
  endtask

  task automatic test_mixed_sign;
    logic signed [31:0] vals [4];
    vals[0] = -7; vals[1] = 3; vals[2] = -1; vals[3] = -9;
    b_ndone = 0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = vals[i];
      @(negedge clk);
      tests_run++;
      if (i < 3 && b_out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL mixed_early_valid after accept %0d: got %b expected 0", i, b_out_valid);
      end else if (i == 3 && {b_out_valid, b_done, b_out_data, b_out_addr} !== {1'b1, 1'b1, 32'sd3, 8'd0}) begin
        tests_failed++;
        $display("FAIL mixed_result: valid %b done %b data %0d addr %0d expected 1 1 3 0",
                 b_out_valid, b_done, b_out_data, b_out_addr);
      end
    end
    b_in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({b_out_valid, b_done, b_busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mixed_after: got %b expected 000", {b_out_valid, b_done, b_busy});
    end
  endtask

  task automatic test_stall_odd_width;
    logic signed [31:0] vals [20];
    logic signed [31:0] exp_d [4];
    vals = '{3, -2, 7, 1, 100, -4, 5, 2, 9, 200, 0, -1, -8, -3, 300, 6, 2, -6, -2, 400};
    exp_d[0] = 5; exp_d[1] = 9; exp_d[2] = 6; exp_d[3] = 0;
    e_qd.delete(); e_qa.delete(); e_ndone = 0;
    @(negedge clk); e_start = 1'b1;
    @(negedge clk); e_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      e_in_valid = (k % 2 == 0);
      e_in_data  = (k % 2 == 0) ? vals[k / 2] : 32'sd999;
      e_start    = (k == 13);
      @(negedge clk);
    end
    e_in_valid = 1'b0;
    e_start    = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if (e_qd.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d expected 4", e_qd.size());
    end
    for (int i = 0; i < 4 && i < e_qd.size(); i++) begin
      tests_run++;
      if (e_qd[i] !== exp_d[i] || e_qa[i] !== 8'(i)) begin
        tests_failed++;
        $display("FAIL stall_out%0d: got %0d@%0d expected %0d@%0d", i, e_qd[i], e_qa[i], exp_d[i], i);
      end
    end
    tests_run++;
    if (e_ndone != 1) begin
      tests_failed++;
      $display("FAIL stall_done: got %0d pulses expected 1", e_ndone);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk); d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      d_in_valid = 1'b1;
      d_in_data  = 32'sd5;
      @(negedge clk);
    end
    d_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({d_busy, d_out_valid, d_in_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_async: got %b expected 000", {d_busy, d_out_valid, d_in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    d_qd.delete(); d_qa.delete(); d_ndone = 0; d_dwv = 0;
    repeat (5) @(negedge clk);
    #1;
    tests_run++;
    if (d_qd.size() != 0 || d_ndone != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got %0d outputs %0d done expected 0 0", d_qd.size(), d_ndone);
    end
    @(negedge clk); d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    for (int i = 0; i < 676; i++) begin
      d_in_valid = 1'b1;
      d_in_data  = 32'sd1;
      @(negedge clk);
    end
    d_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if (d_qd.size() != 169) begin
      tests_failed++;
      $display("FAIL abort_count: got %0d expected 169", d_qd.size());
    end
    for (int i = 0; i < 169 && i < d_qd.size(); i++) begin
      tests_run++;
      if (d_qd[i] !== 32'sd1 || d_qa[i] !== 8'(i)) begin
        tests_failed++;
        $display("FAIL abort_out%0d: got %0d@%0d expected 1@%0d", i, d_qd[i], d_qa[i], i);
      end
    end
    tests_run++;
    if (d_ndone != 1 || !d_dwv) begin
      tests_failed++;
      $display("FAIL abort_done: got %0d pulses coincident=%0d expected 1 coincident=1", d_ndone, d_dwv);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_start = 0; d_in_valid = 0; d_in_data = 0;
    a_start = 0; a_in_valid = 0; a_in_data = 0;
    b_start = 0; b_in_valid = 0; b_in_data = 0;
    e_start = 0; e_in_valid = 0; e_in_data = 0;
    test_reset();
    test_small_frame();
    test_all_negative();
    test_mixed_sign();
    test_stall_odd_width();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
